// File: rtl/noc_pkt_arbiter_if.sv
// Avalon-ST stream bundle carrying the arbiter's merged output toward the NoC.
interface avalonST #(
    parameter int DATA_WIDTH = 64,
    parameter int EW         = (DATA_WIDTH > 8) ? $clog2(DATA_WIDTH / 8) : 1
);
    logic                  valid;
    logic                  ready;
    logic                  sop;
    logic                  eop;
    logic                  error;
    logic [EW-1:0]         empty;
    logic [DATA_WIDTH-1:0] data;

    modport src  (output valid, sop, eop, error, empty, data, input ready);
    modport sink (input valid, sop, eop, error, empty, data, output ready);
endinterface

// File: rtl/noc_pkt_arbiter.sv
// Packet-granular round-robin arbiter: NUM_IN Avalon-ST sources share one
// registered NoC ingress slot, and a packet holds the grant until its eop.
module noc_pkt_arbiter #(
    parameter int  NUM_IN     = 4,
    parameter int  DATA_WIDTH = 64,
    localparam int EW         = (DATA_WIDTH > 8) ? $clog2(DATA_WIDTH / 8) : 1,
    localparam int PW         = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_IN-1:0]            in_valid,
    input  logic [NUM_IN-1:0]            in_sop,
    input  logic [NUM_IN-1:0]            in_eop,
    input  logic [NUM_IN-1:0]            in_error,
    input  logic [NUM_IN*EW-1:0]         in_empty,
    input  logic [NUM_IN*DATA_WIDTH-1:0] in_data,
    output logic [NUM_IN-1:0]            in_ready,
    avalonST.src                         out,
    output logic [NUM_IN-1:0]            o_grant,
    output logic                         o_drop
);
    typedef enum logic {IDLE, LOCKED} state_t;

    state_t                state, next_state;
    logic [PW-1:0]         rr_ptr, owner, winner, sel, next_rr;
    logic                  found, slot_free, accept;
    logic [NUM_IN-1:0]     cand, orphan, grant_q;
    logic                  slot_valid, slot_sop, slot_eop, slot_error, drop_q;
    logic [EW-1:0]         slot_empty;
    logic [DATA_WIDTH-1:0] slot_data;
    int                    idx;

    // Orphans (non-sop beats while unlocked) are swallowed even when the slot
    // is busy; only packet beats depend on slot space and reset.
    always_comb begin
        cand   = in_valid & in_sop;
        orphan = (state == IDLE) ? (in_valid & ~in_sop) : '0;
        found  = 1'b0;
        winner = '0;
        idx    = 0;
        for (int k = 0; k < NUM_IN; k++) begin
            idx = (int'(rr_ptr) + k) % NUM_IN;
            if (!found && cand[PW'(idx)]) begin
                found  = 1'b1;
                winner = PW'(idx);
            end
        end
        sel       = (state == LOCKED) ? owner : winner;
        next_rr   = (int'(sel) == NUM_IN - 1) ? '0 : sel + PW'(1);
        slot_free = !slot_valid || out.ready;
        in_ready  = orphan;
        if (!reset && slot_free) begin
            if (state == LOCKED) in_ready[owner] = 1'b1;
            else if (found)      in_ready[winner] = 1'b1;
        end
        accept     = !reset && slot_free && ((state == LOCKED) ? in_valid[owner] : found);
        next_state = state;
        if (accept) begin
            if (state == IDLE && !in_eop[sel])        next_state = LOCKED;
            else if (state == LOCKED && in_eop[sel])  next_state = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    // The round-robin pointer moves only when a packet completes.
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr     <= '0;
            owner      <= '0;
            grant_q    <= '0;
            drop_q     <= 1'b0;
            slot_valid <= 1'b0;
            slot_sop   <= 1'b0;
            slot_eop   <= 1'b0;
            slot_error <= 1'b0;
            slot_empty <= '0;
            slot_data  <= '0;
        end else begin
            drop_q <= |orphan;
            if (accept) begin
                slot_valid <= 1'b1;
                slot_sop   <= in_sop[sel];
                slot_eop   <= in_eop[sel];
                slot_error <= in_error[sel];
                slot_empty <= in_empty[int'(sel)*EW +: EW];
                slot_data  <= in_data[int'(sel)*DATA_WIDTH +: DATA_WIDTH];
                if (state == IDLE && !in_eop[sel]) begin
                    owner   <= sel;
                    grant_q <= NUM_IN'(1) << sel;
                end else if (in_eop[sel]) begin
                    rr_ptr  <= next_rr;
                    grant_q <= '0;
                end
            end else if (out.ready) begin
                slot_valid <= 1'b0;
            end
        end
    end

    assign out.valid = slot_valid;
    assign out.sop   = slot_sop;
    assign out.eop   = slot_eop;
    assign out.error = slot_error;
    assign out.empty = slot_empty;
    assign out.data  = slot_data;
    assign o_grant   = grant_q;
    assign o_drop    = drop_q;
endmodule

// File: tb/tb_noc_pkt_arbiter.sv
// Directed bench for noc_pkt_arbiter: per-source beat queues drive the inputs,
// a packet-level model predicts every output, and literal checks pin scenarios.
module tb_noc_pkt_arbiter;
    localparam int N  = 4;
    localparam int DW = 64;
    localparam int EW = 3;

    typedef struct {
        bit            idle;
        bit            sop;
        bit            eop;
        bit            err;
        logic [EW-1:0] empty;
        logic [DW-1:0] data;
    } beat_t;

    typedef struct {
        logic [DW-1:0] data;
        int            cyc;
    } obs_t;

    logic            clk       = 1'b0;
    logic            reset     = 1'b1;
    logic [N-1:0]    in_valid  = '0;
    logic [N-1:0]    in_sop    = '0;
    logic [N-1:0]    in_eop    = '0;
    logic [N-1:0]    in_error  = '0;
    logic [N*EW-1:0] in_empty  = '0;
    logic [N*DW-1:0] in_data   = '0;
    logic [N-1:0]    in_ready;
    logic [N-1:0]    o_grant;
    logic            o_drop;
    logic            out_ready = 1'b1;

    avalonST #(.DATA_WIDTH(DW)) out_if ();
    assign out_if.ready = out_ready;

    noc_pkt_arbiter #(.NUM_IN(N), .DATA_WIDTH(DW)) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_sop   (in_sop),
        .in_eop   (in_eop),
        .in_error (in_error),
        .in_empty (in_empty),
        .in_data  (in_data),
        .in_ready (in_ready),
        .out      (out_if),
        .o_grant  (o_grant),
        .o_drop   (o_drop)
    );

    always #5 clk = ~clk;

    int     errors = 0;
    int     checks = 0;
    int     cyc    = 0;
    int     drop_cnt = 0;
    bit     chk_en = 1'b0;
    bit [N-1:0] hs = '0;
    bit [N-1:0] cur_idle = '0;
    beat_t  srcq [N][$];
    obs_t   log_q [$];

    // Model state: lock owner, round-robin pointer and the one output slot.
    bit            m_locked = 1'b0;
    int            m_owner  = 0;
    int            m_rr     = 0;
    bit            m_valid  = 1'b0;
    bit            m_sop = 1'b0, m_eop = 1'b0, m_err = 1'b0, m_drop = 1'b0;
    logic [EW-1:0] m_empty  = '0;
    logic [DW-1:0] m_data   = '0;
    logic [N-1:0]  m_grant  = '0;
    int            mw, ms;
    bit            macc;

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int pick(input logic [N-1:0] c, input int rr);
        for (int k = 0; k < N; k++)
            if (c[(rr + k) % N]) return (rr + k) % N;
        return -1;
    endfunction

    function automatic logic [N-1:0] model_ready();
        logic [N-1:0] r = '0;
        int w;
        if (!m_locked) r = in_valid & ~in_sop;
        if (!reset && (!m_valid || out_ready)) begin
            if (m_locked) r[m_owner] = 1'b1;
            else begin
                w = pick(in_valid & in_sop, m_rr);
                if (w >= 0) r[w] = 1'b1;
            end
        end
        return r;
    endfunction

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (reset) begin
            m_locked = 1'b0; m_owner = 0; m_rr = 0; m_valid = 1'b0;
            m_sop = 1'b0; m_eop = 1'b0; m_err = 1'b0; m_drop = 1'b0;
            m_empty = '0; m_data = '0; m_grant = '0;
        end else begin
            mw     = pick(in_valid & in_sop, m_rr);
            m_drop = !m_locked && (|(in_valid & ~in_sop));
            ms     = m_locked ? m_owner : mw;
            macc   = (!m_valid || out_ready) && (m_locked ? in_valid[m_owner] : (mw >= 0));
            if (macc) begin
                m_valid = 1'b1;
                m_sop   = in_sop[ms];
                m_eop   = in_eop[ms];
                m_err   = in_error[ms];
                m_empty = in_empty[ms*EW +: EW];
                m_data  = in_data[ms*DW +: DW];
                if (!m_locked && !m_eop) begin
                    m_locked = 1'b1;
                    m_owner  = ms;
                    m_grant  = N'(1) << ms;
                end else if (m_eop) begin
                    m_locked = 1'b0;
                    m_rr     = (ms + 1) % N;
                    m_grant  = '0;
                end
            end else if (out_ready) begin
                m_valid = 1'b0;
            end
        end
    end

    // Source drivers: a beat stays presented until its handshake is seen.
    always @(posedge clk) begin
        #1;
        for (int i = 0; i < N; i++) begin
            if (reset) srcq[i].delete();
            else if ((hs[i] || cur_idle[i]) && srcq[i].size() > 0) void'(srcq[i].pop_front());
            cur_idle[i]            = 1'b0;
            in_valid[i]            = 1'b0;
            in_sop[i]              = 1'b0;
            in_eop[i]              = 1'b0;
            in_error[i]            = 1'b0;
            in_empty[i*EW +: EW]   = '0;
            in_data[i*DW +: DW]    = '0;
            if (srcq[i].size() > 0) begin
                if (srcq[i][0].idle) cur_idle[i] = 1'b1;
                else begin
                    in_valid[i]          = 1'b1;
                    in_sop[i]            = srcq[i][0].sop;
                    in_eop[i]            = srcq[i][0].eop;
                    in_error[i]          = srcq[i][0].err;
                    in_empty[i*EW +: EW] = srcq[i][0].empty;
                    in_data[i*DW +: DW]  = srcq[i][0].data;
                end
            end
        end
    end

    always @(negedge clk) begin
        hs = in_valid & in_ready;
        if (chk_en) begin
            check_output("in_ready",  in_ready,     model_ready());
            check_output("out.valid", out_if.valid, m_valid);
            check_output("out.sop",   out_if.sop,   m_sop);
            check_output("out.eop",   out_if.eop,   m_eop);
            check_output("out.error", out_if.error, m_err);
            check_output("out.empty", out_if.empty, m_empty);
            check_output("out.data",  out_if.data,  m_data);
            check_output("o_grant",   o_grant,      m_grant);
            check_output("o_drop",    o_drop,       m_drop);
            if (out_if.valid && out_ready) log_q.push_back('{out_if.data, cyc});
            if (o_drop) drop_cnt++;
        end
    end

    task automatic apply_stimulus(input int s, input int pkt, input int nbeats, input int gap);
        for (int b = 0; b < nbeats; b++) begin
            beat_t t;
            t.idle  = 1'b0;
            t.sop   = (b == 0);
            t.eop   = (b == nbeats - 1);
            t.err   = (s == 3) && t.eop;
            t.empty = t.eop ? EW'(s + 1) : '0;
            t.data  = 64'hA5A5_0000_0000_0000 | 64'(s * 256 + pkt * 16 + b);
            srcq[s].push_back(t);
            if (b == 0)
                for (int g = 0; g < gap; g++) begin
                    beat_t z;
                    z = '{1'b1, 1'b0, 1'b0, 1'b0, '0, '0};
                    srcq[s].push_back(z);
                end
        end
    endtask

    task automatic push_orphan(input int s);
        beat_t t;
        t = '{1'b0, 1'b0, 1'b1, 1'b0, '0, 64'h0BAD};
        srcq[s].push_back(t);
    endtask

    task automatic run(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        @(posedge clk); #2; reset = 1'b1;
        @(posedge clk); #2; chk_en = 1'b1;
        @(negedge clk);
        check_output("reset out.valid", out_if.valid, 0);
        check_output("reset o_grant",   o_grant,      0);
        @(posedge clk); #2; reset = 1'b0;
    endtask

    // Tag of an observed beat: source in the high nibble, beat index low.
    function automatic int obs_tag(input int k);
        if (k >= log_q.size()) return 'hFF;
        return int'(log_q[k].data[11:8]) * 16 + int'(log_q[k].data[3:0]);
    endfunction

    function automatic int obs_cyc(input int k);
        if (k >= log_q.size()) return -1000;
        return log_q[k].cyc;
    endfunction

    int base, dbase;
    bit ok;
    bit pat [12] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

    initial begin
        do_reset();

        // Fairness: four 3-beat packets, expected 0,1,2,3 back to back.
        base = log_q.size();
        for (int s = 0; s < N; s++) apply_stimulus(s, 1, 3, 0);
        run(20);
        check_output("fair count", log_q.size() - base, 12);
        for (int k = 0; k < 12; k++)
            check_output("fair order", obs_tag(base + k), (k / 3) * 16 + (k % 3));
        check_output("fair span", obs_cyc(base + 11) - obs_cyc(base), 11);

        // Lock under a 5-cycle gap from src1 while src2 waits.
        do_reset();
        base = log_q.size();
        apply_stimulus(1, 2, 2, 5);
        apply_stimulus(2, 2, 1, 0);
        run(20);
        check_output("gap count", log_q.size() - base, 3);
        check_output("gap order0", obs_tag(base),     'h10);
        check_output("gap order1", obs_tag(base + 1), 'h11);
        check_output("gap order2", obs_tag(base + 2), 'h20);
        check_output("gap hold",   obs_cyc(base + 1) - obs_cyc(base), 6);
        check_output("gap next",   obs_cyc(base + 2) - obs_cyc(base + 1), 1);

        // Backpressure on a 4-beat packet from src3.
        do_reset();
        base = log_q.size();
        apply_stimulus(3, 3, 4, 0);
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #2; out_ready = pat[i];
        end
        out_ready = 1'b1;
        run(5);
        check_output("bp count", log_q.size() - base, 4);
        for (int k = 0; k < 4; k++)
            check_output("bp order", obs_tag(base + k), 'h30 + k);
        check_output("bp stall", obs_cyc(base + 2) - obs_cyc(base + 1), 3);

        // Single-beat packets alternate between src0 and src2.
        do_reset();
        base = log_q.size();
        apply_stimulus(0, 4, 1, 0);
        apply_stimulus(0, 5, 1, 0);
        apply_stimulus(2, 4, 1, 0);
        apply_stimulus(2, 5, 1, 0);
        run(10);
        check_output("single count", log_q.size() - base, 4);
        check_output("single 0", obs_tag(base),     'h00);
        check_output("single 1", obs_tag(base + 1), 'h20);
        check_output("single 2", obs_tag(base + 2), 'h00);
        check_output("single 3", obs_tag(base + 3), 'h20);
        check_output("single span", obs_cyc(base + 3) - obs_cyc(base), 3);

        // Orphan drop leaves the pointer at src0.
        do_reset();
        base  = log_q.size();
        dbase = drop_cnt;
        push_orphan(1);
        run(6);
        check_output("orphan drops", drop_cnt - dbase, 1);
        check_output("orphan no out", log_q.size() - base, 0);
        apply_stimulus(3, 7, 1, 0);
        apply_stimulus(0, 7, 1, 0);
        run(8);
        check_output("orphan rr first", obs_tag(base),     'h00);
        check_output("orphan rr next",  obs_tag(base + 1), 'h30);

        // Reset on the second beat of a 4-beat packet from src2.
        do_reset();
        apply_stimulus(2, 6, 4, 0);
        ok = 1'b0;
        for (int t = 0; t < 20 && !ok; t++) begin
            @(negedge clk);
            if (in_valid[2] && in_ready[2]) ok = 1'b1;
        end
        check_output("mid sop accept seen", ok, 1);
        @(posedge clk); #2; reset = 1'b1;
        @(negedge clk);
        check_output("mid in_ready[2]", in_ready[2], 0);
        @(posedge clk);
        @(negedge clk);
        check_output("mid out.valid", out_if.valid, 0);
        check_output("mid o_grant",   o_grant,      0);
        @(posedge clk); #2; reset = 1'b0;
        base = log_q.size();
        for (int s = 0; s < N; s++) apply_stimulus(s, 8, 1, 0);
        run(10);
        check_output("post reset count", log_q.size() - base, 4);
        for (int k = 0; k < 4; k++)
            check_output("post reset order", obs_tag(base + k), k * 16);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "[TB] watchdog expired");
    end
endmodule

// File: doc/noc_pkt_arbiter.md
# noc_pkt_arbiter

Packet-granular round-robin arbiter that shares one NoC ingress port between NUM_IN Avalon-ST packet sources, such as several parser output streams. Once a source starts a packet, the grant stays locked to it until the packet's eop beat is accepted, so packets are never interleaved on the NoC. The output is registered, with a one-entry skid, so the arbiter can sit directly in front of the NoC fabric port.

## Interface
- NUM_IN, 4: number of requesting sources, 2..8
- DATA_WIDTH, 64: beat width in bits; EW = $clog2(DATA_WIDTH/8)
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  NUM_IN  per-source beat valid
- in_sop  in  NUM_IN  per-source start of packet
- in_eop  in  NUM_IN  per-source end of packet
- in_error  in  NUM_IN  per-source error flag
- in_empty  in  NUM_IN*EW  per-source empty field; source i uses bits [i*EW +: EW]
- in_data  in  NUM_IN*DATA_WIDTH  per-source data; source i uses bits [i*DATA_WIDTH +: DATA_WIDTH]
- in_ready  out  NUM_IN  per-source ready; ready latency is 0
- out  avalonST.src  -  merged stream (valid/sop/eop/error/empty/data, ready)
- o_grant  out  NUM_IN  one-hot owner of the current packet; 0 when unlocked
- o_drop  out  1  one-cycle pulse when an orphan beat is discarded

## Operation
- Output stage: a registered slot holds one beat in front of `out`.
  - slot_free = !out.valid || out.ready
  - A beat may be accepted from a source only when slot_free.
- State machine, two states:
  - IDLE (reset state):
    - Candidates are sources with in_valid && in_sop.
    - The winner is the first candidate found scanning from rr_ptr upward, modulo NUM_IN.
    - If slot_free, in_ready[winner] = 1 and the beat is accepted this cycle.
    - If the accepted beat has eop=0: go to LOCKED, owner = winner.
    - If the accepted beat has eop=1 (single-beat packet): stay IDLE, rr_ptr = winner+1 mod NUM_IN.
  - LOCKED:
    - in_ready[owner] = slot_free; every other in_ready = 0.
    - When a beat with eop=1 is accepted: go to IDLE, rr_ptr = owner+1 mod NUM_IN, o_grant cleared next cycle.
    - A beat with sop=1 arriving while LOCKED is forwarded unchanged. No repair is done; it is a protocol error upstream.
    - Owner in_valid=0 (a gap) holds the lock; no other source is served.
- Orphan beats: in IDLE, any source with in_valid && !in_sop gets in_ready=1 regardless of slot_free.
  - The beat is discarded and o_drop pulses for one cycle.
  - If several sources drop in the same cycle, o_drop still pulses once.
- rr_ptr advances only on packet completion, never on drops or stalls.
- The winner's sop/eop/error/empty/data are copied into the slot unchanged.
- out.valid is set on accept. It is cleared when out.ready=1 and no new accept happens in that cycle.
- Reset, including mid-packet:
  - Next cycle: state=IDLE, rr_ptr=0, out.valid=0, out.sop/eop/error/empty/data=0, o_grant=0, o_drop=0.
  - A partially sent packet is abandoned; no eop is emitted.
  - in_ready is combinational and is 0 for non-orphan sources during reset.

## Timing
- Latency from input accept to out.valid is 1 cycle.
- Throughput is 1 beat/cycle while out.ready=1, including back-to-back packets from different sources with no idle cycle.
- in_ready depends combinationally on out.ready, in_valid and in_sop. No combinational path exists from in_data to out.
- Arbitration decisions are made in the same cycle as the accepted sop beat.
- When out.ready=0 while out.valid=1, the slot holds its beat and all non-orphan in_ready=0.
- o_grant is registered, valid from the cycle after the sop accept.

## Test plan
- Fairness: all 4 sources continuously offer 3-beat packets, out.ready=1.
  -> Packets appear in order src0,1,2,3,0,… with 12 beats in 12 cycles and no interleaving.
- Lock under gap: src1 sends sop and then drops in_valid for 5 cycles, while src2 is valid with sop.
  -> src2 ready stays 0 until src1's eop is accepted; src2's sop then appears on the cycle after.
- Backpressure: out.ready toggles 1,0,0,1 during a 4-beat packet from src3.
  -> No beat is lost or duplicated, data order is preserved, and out holds its value while ready=0.
- Single-beat packets: src0 and src2 alternate sop=eop=1 beats.
  -> rr_ptr advances each beat and output order is 0,2,0,2 at 1 beat/cycle.
- Orphan drop: src1 presents a beat with sop=0 while IDLE.
  -> in_ready[1]=1, o_drop=1 for one cycle, nothing appears on out, and rr_ptr is unchanged.
- Reset mid-packet: assert reset on the 2nd beat of a 4-beat packet from src2.
  -> The cycle after, out.valid=0 and o_grant=0. After release, src0 is served first when all sources request.
